ahci_dma_rd_mask: RTL

- Upstream neighbour of the DMA read word-stuffer.
- Accepts the 64-bit QWORD stream returned by the AXI read channel for one PRD region and splits each QWORD into two DWORDs.
- Tags each DWORD with a 2-bit word mask (16-bit word granularity) from the region's start-word offset and word count, and buffers them in a show-ahead FIFO.
- Presents data-available, more-than-one-available, read-enable and flush signals in the form the stuffer consumes.

---
 rtl/ahci_dma_rd_mask_pkg.sv | 28 ++
 rtl/ahci_dma_rd_mask_fifo.sv | 67 ++++++
 rtl/ahci_dma_rd_mask.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ahci_dma_rd_mask_pkg.sv
// Shared constants and types for the AHCI DMA read-path word masker.
// The NW_BITS default is also used by the PRD parser, so keep the two in step.
package ahci_dma_rd_mask_pkg;

   localparam int AHCI_DMA_WORDS_PER_QWORD = 4;
   localparam int AHCI_DMA_NW_BITS         = 22;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rd_mask_state_t;

   // Word j of a QWORD is valid unless it sits before the start offset of the
   // first QWORD or past the last valid word of the final QWORD.
   function automatic logic [3:0] qword_mask(input logic       first,
                                             input logic       last,
                                             input logic [1:0] sw,
                                             input logic [1:0] end_w);
      logic [3:0] m;
      for (int j = 0; j < AHCI_DMA_WORDS_PER_QWORD; j++) begin
         m[j] = !(first && (j < int'(sw))) && !(last && (j > int'(end_w)));
      end
      return m;
   endfunction

endpackage

// File: rtl/ahci_dma_rd_mask_fifo.sv
// Show-ahead DWORD+mask FIFO with a dual write port (0, 1 or 2 entries per cycle).
// Entries are packed: slot 0 is always filled first when only one entry is written.
module ahci_dma_rd_mask_fifo #(
   parameter int ADDR = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      wr_n,
   input  logic [31:0]     wr_d0,
   input  logic [1:0]      wr_m0,
   input  logic [31:0]     wr_d1,
   input  logic [1:0]      wr_m1,
   input  logic            rd_en,
   output logic [31:0]     rd_d,
   output logic [1:0]      rd_m,
   output logic [ADDR:0]   count,
   output logic            av,
   output logic            avm
);

   localparam int DEPTH = 1 << ADDR;

   logic [33:0]     mem [DEPTH];
   logic [ADDR-1:0] wptr;
   logic [ADDR-1:0] rptr;
   logic [ADDR-1:0] wptr_p1;
   logic [ADDR:0]   count_nx;
   logic            pop;

   assign pop      = rd_en && av;
   assign wptr_p1  = wptr + ADDR'(1);
   assign count_nx = count + (ADDR+1)'(wr_n) - (ADDR+1)'(pop);

   // av/avm are registered from the post-update occupancy so a pop that
   // leaves one entry drops avm in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         av    <= 1'b0;
         avm   <= 1'b0;
      end else begin
         wptr  <= wptr + ADDR'(wr_n);
         if (pop) begin
            rptr <= rptr + ADDR'(1);
         end
         count <= count_nx;
         av    <= (count_nx != '0);
         avm   <= (count_nx > (ADDR+1)'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (wr_n != 2'd0) begin
         mem[wptr] <= {wr_m0, wr_d0};
      end
      if (wr_n == 2'd2) begin
         mem[wptr_p1] <= {wr_m1, wr_d1};
      end
   end

   // Gating with av keeps the head at zero while empty, including after reset.
   assign rd_d = av ? mem[rptr][31:0]  : 32'd0;
   assign rd_m = av ? mem[rptr][33:32] : 2'd0;

endmodule

// File: rtl/ahci_dma_rd_mask.sv
// Splits one PRD region's AXI read QWORDs into word-masked DWORDs for the
// DMA read word-stuffer, buffered in a show-ahead FIFO.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; empty region goes straight to ST_DONE
//   ST_RUN   | accepting QWORDs until the last one of the region
//   ST_DRAIN | all QWORDs taken; waiting for pipeline and FIFO to empty
//   ST_DONE  | one cycle: done pulse, flush if any DWORD was produced
module ahci_dma_rd_mask
   import ahci_dma_rd_mask_pkg::*;
#(
   parameter int NW_BITS   = AHCI_DMA_NW_BITS,
   parameter int FIFO_ADDR = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         start_word,
   input  logic [NW_BITS-1:0] nwords,
   output logic               busy,
   output logic               done,
   input  logic [63:0]        qin,
   input  logic               qin_valid,
   output logic               qin_ready,
   output logic [31:0]        dout,
   output logic [1:0]         dm,
   output logic               dout_av,
   output logic               dout_avm,
   input  logic               dout_re,
   output logic               flush
);

   localparam int DEPTH = 1 << FIFO_ADDR;

   rd_mask_state_t state, state_nx;

   logic [1:0]           sw_q;
   logic [1:0]           end_w_q;
   logic [NW_BITS-1:0]   qleft;
   logic                 first_q;
   logic                 wrote_any;
   logic [NW_BITS:0]     total;
   logic [1:0]           end_w;
   logic [NW_BITS-1:0]   nq;
   logic                 start_ok;
   logic                 accept;
   logic                 last_q;
   logic                 room;
   logic [3:0]           qmask;
   logic [FIFO_ADDR:0]   fifo_count;
   logic [FIFO_ADDR+1:0] committed;

   logic [1:0]  new_n,  pend_n;
   logic [31:0] new_d0, new_d1, pend_d0, pend_d1;
   logic [1:0]  new_m0, new_m1, pend_m0, pend_m1;

   assign total    = {1'b0, nwords} + (NW_BITS+1)'(start_word);
   assign end_w    = total[1:0] - 2'd1;
   assign nq       = NW_BITS'(total[NW_BITS:2]) + NW_BITS'(total[1:0] != 2'b00);
   assign start_ok = (state == ST_IDLE) && start;
   assign accept   = qin_valid && qin_ready;
   assign last_q   = (qleft == NW_BITS'(1));
   assign qmask    = qword_mask(first_q, last_q, sw_q, end_w_q);

   // Pending pipeline writes count as occupied so two back-to-back accepts
   // can never overrun the FIFO before the first pair lands.
   assign committed = (FIFO_ADDR+2)'(fifo_count) + (FIFO_ADDR+2)'(pend_n);
   assign room      = (committed <= (FIFO_ADDR+2)'(DEPTH - 2));

   always_comb begin
      new_n  = 2'd0;
      new_d0 = qin[31:0];
      new_m0 = qmask[1:0];
      new_d1 = qin[63:32];
      new_m1 = qmask[3:2];
      if (qmask[1:0] != 2'b00) begin
         new_n = (qmask[3:2] != 2'b00) ? 2'd2 : 2'd1;
      end else if (qmask[3:2] != 2'b00) begin
         new_n  = 2'd1;
         new_d0 = qin[63:32];
         new_m0 = qmask[3:2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      qin_ready = 1'b0;
      done      = 1'b0;
      flush     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx = (nwords == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            qin_ready = room;
            if (qin_valid && room && last_q) begin
               state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((fifo_count == '0) && (pend_n == 2'd0)) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            done     = 1'b1;
            flush    = wrote_any;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_q      <= 2'd0;
         end_w_q   <= 2'd0;
         qleft     <= '0;
         first_q   <= 1'b0;
         wrote_any <= 1'b0;
         pend_n    <= 2'd0;
         pend_d0   <= 32'd0;
         pend_d1   <= 32'd0;
         pend_m0   <= 2'd0;
         pend_m1   <= 2'd0;
      end else begin
         if (start_ok) begin
            sw_q      <= start_word;
            end_w_q   <= end_w;
            qleft     <= nq;
            first_q   <= 1'b1;
            wrote_any <= 1'b0;
         end else begin
            if (accept) begin
               qleft   <= qleft - NW_BITS'(1);
               first_q <= 1'b0;
            end
            if (pend_n != 2'd0) begin
               wrote_any <= 1'b1;
            end
         end
         pend_n <= accept ? new_n : 2'd0;
         if (accept) begin
            pend_d0 <= new_d0;
            pend_d1 <= new_d1;
            pend_m0 <= new_m0;
            pend_m1 <= new_m1;
         end
      end
   end

   ahci_dma_rd_mask_fifo #(
      .ADDR (FIFO_ADDR)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_n  (pend_n),
      .wr_d0 (pend_d0),
      .wr_m0 (pend_m0),
      .wr_d1 (pend_d1),
      .wr_m1 (pend_m1),
      .rd_en (dout_re),
      .rd_d  (dout),
      .rd_m  (dm),
      .count (fifo_count),
      .av    (dout_av),
      .avm   (dout_avm)
   );

endmodule
